// File: rtl/stim_pkg.sv
// Shared types, constants and helpers for the weighted stimulus generator.
package stim_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_GAP     = 2'd2,
    S_DONE    = 2'd3
  } stim_state_e;

  // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form).
  localparam logic [31:0] LFSR_POLY   = 32'h8020_0003;
  // Golden-ratio constant used to spread per-lane seeds apart.
  localparam logic [31:0] GOLDEN_SEED = 32'h9E37_79B9;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

  // A zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [31:0] lane_seed(input logic [31:0] seed, input int unsigned k);
    logic [31:0] s;
    s = seed ^ (32'(k) * GOLDEN_SEED);
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

  // Map a 4-bit nibble onto a 4-state lane value using the three thresholds.
  function automatic logic nibble_decode(input logic [3:0] n,
                                         input logic [3:0] one_th,
                                         input logic [3:0] zero_th,
                                         input logic [3:0] x_th,
                                         input logic       x_en);
    if (n >= one_th)       return 1'b1;
    else if (n >= zero_th) return 1'b0;
    else if (n >= x_th)    return x_en ? 1'bx : 1'b0;
    else                   return 1'b0;
  endfunction

endpackage

// File: rtl/stim_lfsr32.sv
// One 32-bit Galois LFSR lane; advances only when adv_i is high.
module stim_lfsr32
  import stim_pkg::*;
#(
  parameter logic [31:0] SEED_P = 32'h1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adv_i,
  output logic [31:0] state_o
);

  logic [31:0] state_q, state_d;

  // Next state: one Galois step when asked, otherwise hold.
  always_comb begin
    state_d = adv_i ? lfsr_step(state_q) : state_q;
  end

  // State register, reloaded with the lane seed on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SEED_P;
    else        state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/weighted_stim_gen.sv
// Weighted random 0/1/X stimulus generator with valid/ready handshake.
//
// state   | meaning
// --------+-------------------------------------------------------
// IDLE    | no run active; waiting for start
// PRESENT | o_data holds a sample, o_valid=1, waiting for i_ready
// GAP     | spacing between samples when PERIOD > 1
// DONE    | all SAMPLES accepted; done=1 until the next start/stop
module weighted_stim_gen
  import stim_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter logic [31:0] SAMPLES = 32'd20000,
  parameter int unsigned PERIOD  = 1,
  parameter logic [31:0] SEED    = 32'h1,
  parameter int unsigned ONE_TH  = 10,
  parameter int unsigned ZERO_TH = 4,
  parameter int unsigned X_TH    = 2,
  parameter bit          X_EN    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             busy,
  output logic             done,
  output logic [31:0]      count
);

  localparam logic [3:0] ONE_N  = 4'(ONE_TH);
  localparam logic [3:0] ZERO_N = 4'(ZERO_TH);
  localparam logic [3:0] X_N    = 4'(X_TH);
  // GAP counts down to zero; entering with PERIOD-2 gives PERIOD-1 gap cycles.
  localparam logic [7:0] GAP_LOAD = (PERIOD > 1) ? 8'(PERIOD - 2) : 8'd0;

  stim_state_e      state_q;
  logic [7:0]       gap_q;
  logic             accept, last, load;
  logic [31:0]      count_inc;
  logic [WIDTH-1:0] lane_val;

  // Handshake decode and the single "load a fresh sample" strobe shared by all lanes.
  always_comb begin
    accept    = (state_q == S_PRESENT) && i_ready && !stop;
    last      = (count == SAMPLES - 32'd1);
    count_inc = (count == 32'hFFFF_FFFF) ? count : count + 32'd1;
    load      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: load = start && !stop && (SAMPLES != 32'd0);
      S_PRESENT:      load = accept && !last && (PERIOD == 1);
      S_GAP:          load = !stop && (gap_q == 8'd0);
      default:        load = 1'b0;
    endcase
  end

  for (genvar k = 0; k < WIDTH; k++) begin : g_lane
    logic [31:0] lfsr_state;
    logic [31:0] lfsr_next;
    logic [27:0] unused_next_hi;

    stim_lfsr32 #(
      .SEED_P(lane_seed(SEED, k))
    ) u_lfsr (
      .clk    (clk),
      .rst_n  (rst_n),
      .adv_i  (load),
      .state_o(lfsr_state)
    );

    // The lane value comes from the nibble after this load's advance.
    assign lfsr_next      = lfsr_step(lfsr_state);
    assign unused_next_hi = lfsr_next[31:4];
    assign lane_val[k]    = nibble_decode(lfsr_next[3:0], ONE_N, ZERO_N, X_N, X_EN);
  end

  // Run-control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gap_q   <= 8'd0;
      o_data  <= '0;
      o_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      count   <= 32'd0;
    end else begin
      if (load) o_data <= lane_val;
      if (stop) begin
        // Abort wins over everything; in IDLE it simply masks a coincident start.
        if (state_q != S_IDLE) begin
          state_q <= S_IDLE;
          o_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (start) begin
              count <= 32'd0;
              if (SAMPLES == 32'd0) begin
                state_q <= S_DONE;
                done    <= 1'b1;
              end else begin
                state_q <= S_PRESENT;
                o_valid <= 1'b1;
                busy    <= 1'b1;
                done    <= 1'b0;
              end
            end
          end
          S_PRESENT: begin
            if (i_ready) begin
              count <= count_inc;
              if (last) begin
                state_q <= S_DONE;
                o_valid <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else if (PERIOD > 1) begin
                state_q <= S_GAP;
                o_valid <= 1'b0;
                gap_q   <= GAP_LOAD;
              end
            end
          end
          S_GAP: begin
            if (gap_q == 8'd0) begin
              state_q <= S_PRESENT;
              o_valid <= 1'b1;
            end else begin
              gap_q <= gap_q - 8'd1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_weighted_stim_gen.sv
// Self-checking bench: cycle table for control outputs, scoreboard for data.
module tb_weighted_stim_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       start_a, stop_a, rdy_a, val_a, busy_a, done_a;
  logic [7:0] dat_a;
  logic [31:0] cnt_a;
  logic       start_b, stop_b, rdy_b, val_b, busy_b, done_b;
  logic [7:0] dat_b;
  logic [31:0] cnt_b;
  logic       start_c, stop_c, rdy_c, val_c, busy_c, done_c;
  logic [7:0] dat_c;
  logic [31:0] cnt_c;

  weighted_stim_gen #(.WIDTH(8), .SAMPLES(32'd4), .PERIOD(1), .SEED(32'h1),
    .ONE_TH(10), .ZERO_TH(4), .X_TH(2), .X_EN(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a), .o_data(dat_a),
    .o_valid(val_a), .i_ready(rdy_a), .busy(busy_a), .done(done_a), .count(cnt_a));

  weighted_stim_gen #(.WIDTH(8), .SAMPLES(32'd3), .PERIOD(4), .SEED(32'h1234_5678),
    .ONE_TH(10), .ZERO_TH(4), .X_TH(2), .X_EN(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b), .o_data(dat_b),
    .o_valid(val_b), .i_ready(rdy_b), .busy(busy_b), .done(done_b), .count(cnt_b));

  weighted_stim_gen #(.WIDTH(8), .SAMPLES(32'd20000), .PERIOD(1), .SEED(32'h0000_ACE1),
    .ONE_TH(10), .ZERO_TH(4), .X_TH(2), .X_EN(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .stop(stop_c), .o_data(dat_c),
    .o_valid(val_c), .i_ready(rdy_c), .busy(busy_c), .done(done_c), .count(cnt_c));

  typedef logic [7:0][31:0] st_t;
  typedef struct packed { logic [7:0] d; logic [7:0] m; } exp_t;
  typedef struct { bit st; bit sp; bit rdy; bit val; bit bsy; bit dn; int cnt; } vec_t;

  int   cmp_n, fail_n;
  exp_t qa[$], qb[$];
  st_t  ma, ma_snap, mb;
  int   pa;
  logic [7:0] log_d[$], log_m[$];
  int   ones_c[8];
  int   xcnt_c;

  // Reference LFSR written bit by bit from the polynomial taps.
  function automatic logic [31:0] m_adv(input logic [31:0] s);
    logic [31:0] r;
    for (int i = 0; i < 31; i++) r[i] = s[i+1];
    r[31] = s[0];
    r[21] = s[22] ^ s[0];
    r[1]  = s[2] ^ s[0];
    r[0]  = s[1] ^ s[0];
    return r;
  endfunction

  function automatic st_t m_seed(input logic [31:0] seed);
    st_t s;
    logic [31:0] kk, v;
    for (int k = 0; k < 8; k++) begin
      kk = 32'(k);
      v = seed ^ (kk * 32'h9E37_79B9);
      s[k] = (v == 32'd0) ? 32'd1 : v;
    end
    return s;
  endfunction

  // One sample: advance every lane, decode nibble; m marks lanes with a known value.
  task automatic m_gen(inout st_t s, input bit xen, output logic [7:0] d, output logic [7:0] m);
    logic [3:0] n;
    for (int k = 0; k < 8; k++) begin
      s[k] = m_adv(s[k]);
      n = s[k][3:0];
      m[k] = 1'b1;
      if (n >= 4'd10)     d[k] = 1'b1;
      else if (n >= 4'd4) d[k] = 1'b0;
      else if (n >= 4'd2) begin d[k] = 1'b0; m[k] = !xen; end
      else                d[k] = 1'b0;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    cmp_n++;
    if (act !== req) begin
      fail_n++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic chk_dat(input string nm, input logic [7:0] act, input logic [7:0] req, input logic [7:0] m);
    cmp_n++;
    if (((act ^ req) & m) !== 8'h00) begin
      fail_n++;
      $display("FAIL %s: got %b required %b (mask %b)", nm, act, req, m);
    end
  endtask

  task automatic push_a();
    logic [7:0] d, m;
    ma_snap = ma;
    pa = 0;
    repeat (4) begin m_gen(ma, 1'b1, d, m); qa.push_back({d, m}); end
  endtask

  // After a stop with PERIOD=1 the DUT has loaded one sample beyond those accepted.
  task automatic stop_fix_a();
    logic [7:0] d, m;
    ma = ma_snap;
    repeat (pa + 1) m_gen(ma, 1'b1, d, m);
    qa.delete();
  endtask

  task automatic push_b();
    logic [7:0] d, m;
    repeat (3) begin m_gen(mb, 1'b0, d, m); qb.push_back({d, m}); end
  endtask

  task automatic mon_step();
    exp_t e;
    if (!rst_n) return;
    if (val_a && rdy_a && !stop_a) begin
      if (qa.size() == 0) begin
        cmp_n++; fail_n++;
        $display("FAIL sb_a: accept of %b with nothing expected", dat_a);
      end else begin
        e = qa.pop_front();
        chk_dat("sb_a data", dat_a, e.d, e.m);
        log_m.push_back(e.m);
      end
      log_d.push_back(dat_a);
      pa++;
    end
    if (val_b && rdy_b && !stop_b) begin
      if (qb.size() == 0) begin
        cmp_n++; fail_n++;
        $display("FAIL sb_b: accept of %b with nothing expected", dat_b);
      end else begin
        e = qb.pop_front();
        chk_dat("sb_b data", dat_b, e.d, e.m);
      end
    end
    if (val_c && rdy_c && !stop_c) begin
      for (int k = 0; k < 8; k++) ones_c[k] += (dat_c[k] === 1'b1) ? 1 : 0;
      if ($isunknown(dat_c)) xcnt_c++;
    end
  endtask

  vec_t vec [18];
  logic [7:0] first_d [4];
  logic [7:0] first_m [4];
  logic [7:0] snap;
  int vcyc[$];
  int base;
  bit prev_busy;

  initial begin
    vec = '{
      '{1,0,1, 1,1,0,0}, '{0,0,1, 1,1,0,1}, '{0,0,1, 1,1,0,2}, '{0,0,1, 1,1,0,3},
      '{0,0,1, 0,0,1,4}, '{0,0,0, 0,0,1,4},
      '{1,0,1, 1,1,0,0}, '{0,0,1, 1,1,0,1}, '{1,0,1, 1,1,0,2}, '{0,1,1, 0,0,0,2},
      '{0,0,1, 0,0,0,2}, '{1,1,1, 0,0,0,2},
      '{1,0,0, 1,1,0,0}, '{0,0,1, 1,1,0,1}, '{0,0,1, 1,1,0,2}, '{0,0,1, 1,1,0,3},
      '{0,0,1, 0,0,1,4}, '{0,0,1, 0,0,1,4}
    };
    cmp_n = 0; fail_n = 0; pa = 0; xcnt_c = 0;
    for (int k = 0; k < 8; k++) ones_c[k] = 0;
    {start_a, stop_a, rdy_a, start_b, stop_b, rdy_b, start_c, stop_c, rdy_c} = '0;
    rst_n = 1'b0;
    ma = m_seed(32'h1);
    mb = m_seed(32'h1234_5678);
    fork
      forever begin @(negedge clk); mon_step(); end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("reset o_valid", val_a, 0);
    chk("reset busy", busy_a, 0);
    chk("reset done", done_a, 0);
    chk("reset count", cnt_a, 0);
    chk("reset o_data", dat_a, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Control table on instance A (SAMPLES=4, PERIOD=1).
    prev_busy = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (vec[i].st && !vec[i].sp && !prev_busy) push_a();
      if (vec[i].sp && prev_busy) stop_fix_a();
      start_a = vec[i].st; stop_a = vec[i].sp; rdy_a = vec[i].rdy;
      @(posedge clk); #1;
      chk($sformatf("row%0d o_valid", i), val_a, vec[i].val);
      chk($sformatf("row%0d busy", i), busy_a, vec[i].bsy);
      chk($sformatf("row%0d done", i), done_a, vec[i].dn);
      chk($sformatf("row%0d count", i), cnt_a, 64'(vec[i].cnt));
      prev_busy = vec[i].bsy;
    end
    start_a = 0; stop_a = 0;
    for (int i = 0; i < 4; i++) begin
      first_d[i] = (log_d.size() > i) ? log_d[i] : 8'h00;
      first_m[i] = (log_m.size() > i) ? log_m[i] : 8'h00;
    end

    // Stall for 5 cycles mid-run; data must hold and later samples follow the model.
    push_a();
    start_a = 1; rdy_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    @(posedge clk); #1;
    snap = dat_a;
    rdy_a = 0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall o_data", dat_a, snap);
      chk("stall o_valid", val_a, 1);
    end
    chk("stall count", cnt_a, 1);
    rdy_a = 1;
    for (int t = 0; t < 20 && !done_a; t++) begin @(posedge clk); #1; end
    chk("stall run done", done_a, 1);
    chk("stall run count", cnt_a, 4);

    // PERIOD=4 spacing on instance B.
    push_b();
    start_b = 1; rdy_b = 1;
    for (int t = 0; t < 16; t++) begin
      @(posedge clk); #1;
      start_b = 0;
      if (val_b) vcyc.push_back(t);
      if (t == 2) chk("gap busy", busy_b, 1);
    end
    chk("period valid pulses", vcyc.size(), 3);
    chk("period pulse0", (vcyc.size() > 0) ? vcyc[0] : -1, 0);
    chk("period pulse1", (vcyc.size() > 1) ? vcyc[1] : -1, 4);
    chk("period pulse2", (vcyc.size() > 2) ? vcyc[2] : -1, 8);
    chk("period count", cnt_b, 3);
    chk("period done", done_b, 1);
    chk("period busy", busy_b, 0);

    // 20000-sample distribution on instance C (X disabled).
    start_c = 1; rdy_c = 1;
    @(posedge clk); #1;
    start_c = 0;
    for (int t = 0; t < 21000 && !done_c; t++) begin @(posedge clk); #1; end
    chk("dist done", done_c, 1);
    chk("dist count", cnt_c, 20000);
    chk("dist x samples", xcnt_c, 0);
    for (int k = 0; k < 8; k++)
      chk($sformatf("dist ones lane%0d in 7100..7900 (ones=%0d)", k, ones_c[k]),
          (ones_c[k] >= 7100 && ones_c[k] <= 7900) ? 1 : 0, 1);

    // Async reset mid-run, then rerun must repeat the first-run sequence.
    push_a();
    start_a = 1; rdy_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async rst o_valid", val_a, 0);
    chk("async rst busy", busy_a, 0);
    chk("async rst done", done_a, 0);
    chk("async rst count", cnt_a, 0);
    chk("async rst o_data", dat_a, 0);
    qa.delete();
    ma = m_seed(32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    base = log_d.size();
    push_a();
    start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    for (int t = 0; t < 10 && !done_a; t++) begin @(posedge clk); #1; end
    chk("rerun done", done_a, 1);
    for (int i = 0; i < 4; i++)
      chk_dat($sformatf("rerun sample%0d", i),
              (log_d.size() > base + i) ? log_d[base+i] : 8'hxx, first_d[i], first_m[i]);
    chk("scoreboard a drained", qa.size(), 0);
    chk("scoreboard b drained", qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule

// File: doc/weighted_stim_gen.md
WEIGHTED_STIM_GEN -- requirements
Module: weighted_stim_gen

Interface
REQ-001 Parameter WIDTH, default 8: number of output bit lanes, 1..64.
REQ-002 Parameter SAMPLES, default 20000: number of samples per run, 0..2^32-1.
REQ-003 Parameter PERIOD, default 1: minimum cycles from one accepted sample to the next o_valid, 1..255.
REQ-004 Parameter SEED, default 32'h1: base LFSR seed; must be nonzero.
REQ-005 Parameters ONE_TH=10, ZERO_TH=4, X_TH=2, default as shown: nibble thresholds; require 16 > ONE_TH > ZERO_TH > X_TH > 0.
REQ-006 Parameter X_EN, default 1: 1 allows X on lanes, 0 forces 0 in place of X.
REQ-007 clk  in  1  single clock; all logic on the rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  one-cycle pulse that begins a run.
REQ-010 stop  in  1  one-cycle pulse that aborts a run.
REQ-011 o_data  out  WIDTH  current sample, 4-state.
REQ-012 o_valid  out  1  o_data holds an unaccepted sample.
REQ-013 i_ready  in  1  consumer accepts the sample on clk when o_valid=1.
REQ-014 busy  out  1  run in progress.
REQ-015 done  out  1  last run completed all SAMPLES.
REQ-016 count  out  32  samples accepted in the current or last run.

Function
REQ-017 FSM states are IDLE, PRESENT, GAP and DONE.
REQ-018 IDLE + start: if SAMPLES=0, go to DONE; otherwise load a fresh sample into o_data, set o_valid and go to PRESENT.
REQ-019 PRESENT + i_ready is an accept: count increments by 1 that cycle.
REQ-020 On an accept with count=SAMPLES-1, clear o_valid and go to DONE.
REQ-021 On any other accept: with PERIOD=1, load a new sample and keep o_valid=1 (zero bubbles); with PERIOD>1, clear o_valid and go to GAP.
REQ-022 GAP holds PERIOD-1 cycles, then loads a new sample, sets o_valid and enters PRESENT.
REQ-023 While o_valid=1 and i_ready=0, o_data and o_valid shall stay stable and the LFSRs shall not advance.
REQ-024 Each lane k has its own 32-bit Galois LFSR (polynomial x^32+x^22+x^2+x+1), seeded with SEED ^ (k*32'h9E3779B9); a zero result is forced to 1.
REQ-025 Every lane's LFSR advances once per sample load, and only on a load.
REQ-026 Lane value from nibble n = lfsr[3:0] after the advance: n>=ONE_TH gives 1; ZERO_TH<=n<ONE_TH gives 0; X_TH<=n<ZERO_TH gives X (or 0 when X_EN=0); n<X_TH gives 0.
REQ-027 stop in any non-IDLE state: clear o_valid and busy, go to IDLE, keep count, leave done=0.
REQ-028 start and stop in the same cycle: stop wins.
REQ-029 start while busy is ignored.
REQ-030 In DONE, done=1 and busy=0; start clears count and done and begins a new run without reseeding (the sequence continues).
REQ-031 busy=1 exactly in PRESENT and GAP.
REQ-032 count saturates at 2^32-1.

Reset
REQ-033 With rst_n=0: state=IDLE, o_data=0, o_valid=0, busy=0, done=0, count=0, gap counter=0, and each LFSR loads its REQ-024 seed.
REQ-034 Reset mid-run discards the presented sample with no accept counted.
REQ-035 The first run after reset produces a sequence identical to the run after any other reset.

Structure
REQ-036 Package stim_pkg holds the FSM state enum, the LFSR polynomial constant, the golden-ratio seed constant and a nibble-to-4-state decode function.
REQ-037 Sub-module stim_lfsr32 (seed parameter, advance enable, 32-bit state out) is instantiated once per lane via generate.

Verification
REQ-038 WIDTH=8, SAMPLES=4, PERIOD=1, i_ready=1, start -> o_valid high for 4 consecutive cycles, count=4, done=1, busy=0.
REQ-039 SAMPLES=3, PERIOD=4, i_ready=1 -> o_valid pulses exactly 4 cycles apart, count=3, then DONE.
REQ-040 i_ready held 0 for 5 cycles mid-run -> o_data unchanged across all 5 cycles; sequence afterwards matches a zero-stall reference model.
REQ-041 X_EN=0 with 20000 samples -> no X on any lane; 1s about 37.5% and 0s about 62.5% per lane, within +/-2%.
REQ-042 stop after 2 accepts, then start -> count restarts at 0, done stays 0 until 4 accepts; start+stop together in IDLE -> stays IDLE.
REQ-043 rst_n pulsed low mid-run -> all outputs 0 asynchronously; after release, a rerun reproduces the first-run o_data sequence.
